// File: rtl/modcount_pkg.sv
// Shared types and helpers for the modulo-N counter.
// Optional feature macro used across the block: MODCOUNT_RUNTIME_TERM_EN.
package modcount_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_ONESHOT = 1'b1} mode_e;

  // Loads at or above the modulus saturate to the top count instead of aliasing.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] mod);
    logic [31:0] res_s;
    if (val >= mod) begin
      res_s = mod - 32'd1;
    end else begin
      res_s = val;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/modcount_if.sv
// Control/status bundle of the modulo-N counter.
// Carries i_term only when MODCOUNT_RUNTIME_TERM_EN is defined.
interface modcount_if #(
  parameter int WIDTH = 7
);
  logic             i_enable;
  logic             i_dir;
  logic             i_mode;
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
`ifdef MODCOUNT_RUNTIME_TERM_EN
  logic [WIDTH-1:0] i_term;
`endif
  logic [WIDTH-1:0] o_val;
  logic             o_last;
  logic             o_wrap;
  logic             o_done;

  modport master (
    output i_enable, i_dir, i_mode, i_clear, i_load, i_load_val,
`ifdef MODCOUNT_RUNTIME_TERM_EN
    output i_term,
`endif
    input  o_val, o_last, o_wrap, o_done
  );

  modport slave (
    input  i_enable, i_dir, i_mode, i_clear, i_load, i_load_val,
`ifdef MODCOUNT_RUNTIME_TERM_EN
    input  i_term,
`endif
    output o_val, o_last, o_wrap, o_done
  );
endinterface

// File: rtl/modcount_next.sv
// Combinational next-state logic of the modulo-N counter: value, wrap pulse, done flag.
// With MODCOUNT_RUNTIME_TERM_EN the up-terminal is min(term, MOD-1) instead of MOD-1.
module modcount_next
  import modcount_pkg::*;
#(
  parameter int MOD   = 118,
  parameter int WIDTH = $clog2(MOD)
) (
  input  logic [WIDTH-1:0] val,
  input  logic             done,
  input  logic             enable,
  input  logic             dir,
  input  logic             mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODCOUNT_RUNTIME_TERM_EN
  input  logic [WIDTH-1:0] term,
`endif
  output logic [WIDTH-1:0] up_term,
  output logic [WIDTH-1:0] val_nxt,
  output logic             wrap_nxt,
  output logic             done_nxt
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  dir_e             dir_s;
  mode_e            mode_s;
  logic [WIDTH-1:0] load_clamped_s;

  assign dir_s          = dir_e'(dir);
  assign mode_s         = mode_e'(mode);
  assign load_clamped_s = WIDTH'(clamp_load(32'(load_val), 32'(MOD)));

`ifdef MODCOUNT_RUNTIME_TERM_EN
  // Effective up-terminal saturates the runtime request at the modulus.
  always_comb begin
    if (term > MAX_VAL) begin
      up_term = MAX_VAL;
    end else begin
      up_term = term;
    end
  end
`else
  assign up_term = MAX_VAL;
`endif

  // Priority clear > load > enable > hold; any value above the up-terminal counts as terminal.
  always_comb begin
    val_nxt  = val;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (clear) begin
      done_nxt = 1'b0;
      if (dir_s == DIR_DOWN) begin
        val_nxt = up_term;
      end else begin
        val_nxt = ZERO_VAL;
      end
    end else if (load) begin
      val_nxt  = load_clamped_s;
      done_nxt = 1'b0;
    end else if (enable) begin
      case (dir_s)
        DIR_UP: begin
          if (val >= up_term) begin
            if (mode_s == MODE_ONESHOT) begin
              done_nxt = 1'b1;
            end else begin
              val_nxt  = ZERO_VAL;
              wrap_nxt = 1'b1;
            end
          end else begin
            val_nxt = val + ONE_VAL;
          end
        end
        DIR_DOWN: begin
          if (val == ZERO_VAL) begin
            if (mode_s == MODE_ONESHOT) begin
              done_nxt = 1'b1;
            end else begin
              val_nxt  = up_term;
              wrap_nxt = 1'b1;
            end
          end else begin
            val_nxt = val - ONE_VAL;
          end
        end
        default: begin
          val_nxt = val;
        end
      endcase
    end else begin
      val_nxt = val;
    end
  end

endmodule

// File: rtl/modcount.sv
// Parametrised modulo-N up/down counter with wrap/one-shot modes, load, clear, wrap pulse and done flag.
// Optional runtime terminal via MODCOUNT_RUNTIME_TERM_EN (adds i_term to modcount_if).
module modcount
  import modcount_pkg::*;
#(
  parameter int MOD       = 118,
  parameter int WIDTH     = $clog2(MOD),
  parameter int RESET_VAL = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  modcount_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_VAL_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_VAL    = {WIDTH{1'b0}};

  if (MOD < 2) begin : g_bad_mod
    $error("modcount: MOD must be at least 2");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MOD)) begin : g_bad_reset_val
    $error("modcount: RESET_VAL must lie in 0..MOD-1");
  end

  logic [WIDTH-1:0] val_r;
  logic             wrap_r;
  logic             done_r;
  logic [WIDTH-1:0] val_nxt_s;
  logic             wrap_nxt_s;
  logic             done_nxt_s;
  logic [WIDTH-1:0] up_term_s;
  logic             last_s;

  modcount_next #(
    .MOD   (MOD),
    .WIDTH (WIDTH)
  ) u_next (
    .val      (val_r),
    .done     (done_r),
    .enable   (bus.i_enable),
    .dir      (bus.i_dir),
    .mode     (bus.i_mode),
    .clear    (bus.i_clear),
    .load     (bus.i_load),
    .load_val (bus.i_load_val),
`ifdef MODCOUNT_RUNTIME_TERM_EN
    .term     (bus.i_term),
`endif
    .up_term  (up_term_s),
    .val_nxt  (val_nxt_s),
    .wrap_nxt (wrap_nxt_s),
    .done_nxt (done_nxt_s)
  );

  // Count, wrap pulse and sticky done; reset drops any pending pulse immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_r  <= RESET_VAL_W;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      val_r  <= val_nxt_s;
      wrap_r <= wrap_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Terminal detect follows i_dir combinationally, no register stage.
  always_comb begin
    last_s = 1'b0;
    if (dir_e'(bus.i_dir) == DIR_DOWN) begin
      last_s = (val_r == ZERO_VAL);
    end else begin
      last_s = (val_r == up_term_s);
    end
  end

  assign bus.o_val  = val_r;
  assign bus.o_wrap = wrap_r;
  assign bus.o_done = done_r;
  assign bus.o_last = last_s;

endmodule

// File: tb/tb_modcount.sv
// Scoreboard bench: two counters (MOD=118 and MOD=12) share one randomized/directed stimulus
// stream; a reference model pushes expectations, a monitor pops and compares after each edge.
module tb_modcount;

  typedef struct packed {
    logic [7:0] val;
    logic       wrap;
    logic       done;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       en_v, dir_v, mode_v, clr_v, ld_v;
  logic [6:0] lv_v;
  logic [6:0] term_v = 7'h7f;
  logic       want_rst_n;

  modcount_if #(.WIDTH(7)) bus_a ();
  modcount_if #(.WIDTH(4)) bus_b ();

  assign bus_a.i_enable   = en_v;
  assign bus_a.i_dir      = dir_v;
  assign bus_a.i_mode     = mode_v;
  assign bus_a.i_clear    = clr_v;
  assign bus_a.i_load     = ld_v;
  assign bus_a.i_load_val = lv_v;
  assign bus_b.i_enable   = en_v;
  assign bus_b.i_dir      = dir_v;
  assign bus_b.i_mode     = mode_v;
  assign bus_b.i_clear    = clr_v;
  assign bus_b.i_load     = ld_v;
  assign bus_b.i_load_val = lv_v[3:0];
`ifdef MODCOUNT_RUNTIME_TERM_EN
  assign bus_a.i_term     = term_v;
  assign bus_b.i_term     = term_v[3:0];
`endif

  modcount #(.MOD(118)) u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  modcount #(.MOD(12))  u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  int   mods  [2] = '{118, 12};
  int   masks [2] = '{127, 15};
  int   m_val [2];
  bit   m_wrap[2];
  bit   m_done[2];
  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_term(input int k);
    int t;
    t = int'(term_v) & masks[k];
    return (t < mods[k] - 1) ? t : mods[k] - 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_wrap[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int m, tu, lvk;
    m   = mods[k];
    tu  = eff_term(k);
    lvk = int'(lv_v) & masks[k];
    m_wrap[k] = 1'b0;
    if (clr_v) begin
      m_val[k] = dir_v ? tu : 0;
      m_done[k] = 1'b0;
    end else if (ld_v) begin
      m_val[k] = (lvk >= m) ? m - 1 : lvk;
      m_done[k] = 1'b0;
    end else if (en_v) begin
      if (!dir_v) begin
        if (m_val[k] >= tu) begin
          if (mode_v) m_done[k] = 1'b1;
          else begin m_val[k] = 0; m_wrap[k] = 1'b1; end
        end else m_val[k] = m_val[k] + 1;
      end else begin
        if (m_val[k] == 0) begin
          if (mode_v) m_done[k] = 1'b1;
          else begin m_val[k] = tu; m_wrap[k] = 1'b1; end
        end else m_val[k] = m_val[k] - 1;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.val  = 8'(m_val[k]);
      e.wrap = m_wrap[k];
      e.done = m_done[k];
      e.last = dir_v ? (m_val[k] == 0) : (m_val[k] == eff_term(k));
      if (k == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict the state after the next posedge.
  task automatic step(input bit e, input bit d, input bit mo, input bit c, input bit l, input int v);
    @(negedge clk);
    reset_n = want_rst_n;
    en_v = e; dir_v = d; mode_v = mo; clr_v = c; ld_v = l; lv_v = 7'(v);
    if (!reset_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    push_exp();
  endtask

  // Async reset between edges: one expectation for the reset edge, one for the following posedge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    model_reset();
    push_exp();
    want_rst_n = 1'b0;
    reset_n    = 1'b0;
    push_exp();
  endtask

  // Monitor: compares both counters after every posedge and every reset assertion.
  initial begin
    exp_t e;
    #2;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        chk("queue_underflow", 32'(qa.size() + qb.size()), 32'd2);
      end else begin
        e = qa.pop_front();
        chk("a_val",  32'(bus_a.o_val),  32'(e.val));
        chk("a_wrap", 32'(bus_a.o_wrap), 32'(e.wrap));
        chk("a_done", 32'(bus_a.o_done), 32'(e.done));
        chk("a_last", 32'(bus_a.o_last), 32'(e.last));
        e = qb.pop_front();
        chk("b_val",  32'(bus_b.o_val),  32'(e.val));
        chk("b_wrap", 32'(bus_b.o_wrap), 32'(e.wrap));
        chk("b_done", 32'(bus_b.o_done), 32'(e.done));
        chk("b_last", 32'(bus_b.o_last), 32'(e.last));
      end
    end
  end

  initial begin
    bit rd, rm;
    reset_n = 1'b0; want_rst_n = 1'b0;
    en_v = 1'b0; dir_v = 1'b0; mode_v = 1'b0; clr_v = 1'b0; ld_v = 1'b0; lv_v = 7'd0;
    model_reset();
    push_exp();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    want_rst_n = 1'b1;

    // Up/wrap from reset with enable held: 118 wraps after 117, 12 wraps repeatedly.
    for (int i = 0; i < 125; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Down/wrap after clear.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // One-shot up, then load clears done.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Load clamp, then clear beats load.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 125);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5);
    // Reach 7, then async reset between edges.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    want_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef MODCOUNT_RUNTIME_TERM_EN
    // Runtime terminal 9, then lowered to 4 while above it.
    term_v = 7'd9;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7);
    term_v = 7'd4;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    term_v = 7'h7f;
`endif
    // Randomized stream with slowly changing direction and mode.
    rd = 1'b0; rm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rd = ~rd;
      if ($urandom_range(0, 23) == 0) rm = ~rm;
`ifdef MODCOUNT_RUNTIME_TERM_EN
      if ($urandom_range(0, 63) == 0) term_v = 7'($urandom_range(0, 127));
`endif
      step(($urandom_range(0, 3) != 0), rd, rm,
           ($urandom_range(0, 47) == 0), ($urandom_range(0, 31) == 0),
           int'($urandom_range(0, 127)));
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/modcount.md
Name: modcount

Overview:
- Parametrised modulo-N counter; the next generation of the single-direction upcount.
- Adds up/down direction, wrap or one-shot mode, synchronous load and clear, a registered wrap pulse and a sticky done flag.
- Used as a timebase, prescaler or cascaded digit counter: o_wrap of one stage drives i_enable of the next.

Parameters:
- MOD, 118, modulus; counts 0..MOD-1; MOD >= 2.
- WIDTH, $clog2(MOD), bit width of o_val and i_load_val.
- RESET_VAL, 0, value of o_val after reset; must be < MOD (elaboration-time check).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- i_enable  input  1  count enable, sampled at posedge
- i_dir  input  1  0 = up, 1 = down
- i_mode  input  1  0 = wrap, 1 = one-shot
- i_clear  input  1  synchronous clear to the start value
- i_load  input  1  synchronous load of i_load_val
- i_load_val  input  WIDTH  load value
- o_val  output  WIDTH  registered count
- o_last  output  1  combinational; o_val equals the terminal value for the current i_dir
- o_wrap  output  1  registered one-cycle pulse on wrap
- o_done  output  1  registered sticky flag, one-shot mode only

Behaviour:
- Reset (reset_n low, async): o_val = RESET_VAL, o_wrap = 0, o_done = 0. Deasserts synchronously to clk, externally guaranteed.
- Terminal value: MOD-1 when i_dir = 0; 0 when i_dir = 1. o_last = (o_val == terminal), combinational, so it changes the same cycle i_dir changes.
- Priority per posedge: i_clear > i_load > i_enable > hold.
- i_clear: o_val <- 0 if i_dir = 0, else MOD-1. o_done <- 0, o_wrap <- 0.
- i_load: o_val <- i_load_val, clamped to MOD-1 if i_load_val >= MOD. o_done <- 0, o_wrap <- 0.
- Enabled count, not at terminal: o_val +/- 1; o_wrap <- 0.
- Enabled, at terminal, i_mode = 0 (wrap): o_val <- 0 (up) or MOD-1 (down); o_wrap <- 1 for exactly that cycle, coincident with the new o_val.
- Enabled, at terminal, i_mode = 1 (one-shot): o_val holds; o_done <- 1 and stays set until clear, load or reset; o_wrap stays 0.
- Not enabled: o_val and o_done hold; o_wrap <- 0.
- i_dir or i_mode change: takes effect on the next posedge; no extra state.
- o_done in wrap mode: never set; switching to wrap mode does not clear it.
- Arithmetic is modulo MOD, never modulo 2^WIDTH. With MOD not a power of 2, o_val never exceeds MOD-1.
- Latency: one clock from enable or load to the new o_val.
- Reset mid-count: immediate async return to the reset state; no pending pulse survives.

Optional Feature:
- Macro: MODCOUNT_RUNTIME_TERM_EN.
- Defined:
  - Adds input i_term [WIDTH-1:0]. The up-terminal becomes min(i_term, MOD-1); the down wrap target becomes the same value.
  - If o_val > effective terminal, the next enabled up-count wraps to 0 with an o_wrap pulse, or sets o_done in one-shot mode.
  - i_clear in down direction loads the effective terminal.
- Not defined: no port; terminal fixed at MOD-1.

Decomposition:
- Package modcount_pkg:
  - typedef enum logic {DIR_UP, DIR_DOWN} dir_e
  - typedef enum logic {MODE_WRAP, MODE_ONESHOT} mode_e
  - function clamp_load(val, mod)
- Sub-module modcount_next: combinational next-value, wrap and done logic. The top holds only the registers and o_last.

Test Plan:
- MOD = 118, up, wrap, enable held from reset: o_last first high when o_val = 117; next edge o_val = 0 and o_wrap high for 1 cycle.
- MOD = 12, down, wrap: from reset after i_clear, o_val = 11; 11 edges later o_val = 0 with o_last high; next edge o_val = 11 and o_wrap pulses.
- MOD = 12, one-shot, up, enable held: o_val stops at 11 and o_done rises; further enables hold both; i_load with 3 gives o_val = 3, o_done = 0.
- Load clamp and priority: MOD = 12, i_load_val = 15 gives o_val = 11. i_clear and i_load together with i_dir = 0 give o_val = 0.
- Async reset: assert reset_n low between edges with o_val = 7: o_val = 0, o_wrap = 0, o_done = 0 immediately, without waiting for a clock edge.
- With MODCOUNT_RUNTIME_TERM_EN, MOD = 118, i_term = 9, up, wrap: counts 0..9 then wraps with o_wrap. Then i_term = 4 while o_val = 7: next enabled edge o_val = 0 with o_wrap.
